// File: rtl/motor_ramp_if.sv
// Speed-command channel into motor_ramp: valid/ready handshake carrying signed per-side targets.
// Transfer happens when cmd_valid & cmd_ready are both high at a clock edge.
interface motor_ramp_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [10:0] cmd_left;
    logic signed [10:0] cmd_right;

    modport master (
        output cmd_valid,
        output cmd_left,
        output cmd_right,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_left,
        input  cmd_right,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp.sv
// Dual-channel duty slew limiter with brake-and-dwell before reversal; outputs feed the PWM duty/dir pins.
// Outputs registered; duty moves only on tick edges. cmd_ready drops during estop and for one cycle after reset.
module motor_ramp_chan #(
    parameter int STEP        = 10,
    parameter int DWELL_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        estop,
    input  logic [31:0] tgt_mag,
    input  logic        tgt_neg,
    output logic [31:0] duty,
    output logic        dir,
    output logic        idle_next
);
    typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DWELL} state_t;

    localparam logic [31:0] STEP_W  = 32'(STEP);
    localparam logic [31:0] DWELL_W = 32'(DWELL_TICKS);

    state_t      state, state_n;
    logic [31:0] duty_n;
    logic [31:0] dwell_cnt, dwell_cnt_n;
    logic        dir_n;
    logic        reversing;

    // tgt_neg == dir means the target points against the current bridge direction
    assign reversing = (tgt_mag != 32'd0) && (tgt_neg == dir);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty      <= 32'd0;
            dir       <= 1'b1;
            dwell_cnt <= 32'd0;
        end else begin
            state     <= state_n;
            duty      <= duty_n;
            dir       <= dir_n;
            dwell_cnt <= dwell_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        duty_n      = duty;
        dir_n       = dir;
        dwell_cnt_n = dwell_cnt;
        if (estop) begin
            state_n     = IDLE;
            duty_n      = 32'd0;
            dwell_cnt_n = 32'd0;
        end else begin
            case (state)
                DWELL: begin
                    if (tick) begin
                        if (dwell_cnt + 32'd1 >= DWELL_W) begin
                            if (tgt_mag != 32'd0) begin
                                dir_n = ~tgt_neg;
                            end
                            state_n     = (tgt_mag == 32'd0) ? IDLE : RAMP;
                            dwell_cnt_n = 32'd0;
                        end else begin
                            dwell_cnt_n = dwell_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    // IDLE, RAMP and BRAKE share one decision so a fresh target acts on the very next tick
                    if (reversing) begin
                        state_n = BRAKE;
                        if (tick) begin
                            duty_n = (duty > STEP_W) ? duty - STEP_W : 32'd0;
                        end
                        if (duty_n == 32'd0) begin
                            state_n     = DWELL;
                            dwell_cnt_n = 32'd0;
                        end
                    end else if (duty != tgt_mag) begin
                        state_n = RAMP;
                        if (tick) begin
                            if (duty < tgt_mag) begin
                                if (tgt_mag - duty <= STEP_W) begin
                                    duty_n  = tgt_mag;
                                    state_n = IDLE;
                                end else begin
                                    duty_n = duty + STEP_W;
                                end
                            end else begin
                                if (duty - tgt_mag <= STEP_W) begin
                                    duty_n  = tgt_mag;
                                    state_n = IDLE;
                                end else begin
                                    duty_n = duty - STEP_W;
                                end
                            end
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    assign idle_next = (state_n == IDLE);
endmodule

module motor_ramp #(
    parameter int TICK_DIV    = 1000,
    parameter int STEP        = 10,
    parameter int DUTY_MAX    = 1000,
    parameter int DWELL_TICKS = 50
) (
    input  logic         clk,
    input  logic         rst,
    motor_ramp_if.slave  bus,
    input  logic         estop,
    output logic [31:0]  duty_left,
    output logic [31:0]  duty_right,
    output logic         dir_left,
    output logic         dir_right,
    output logic         settled
);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] MAX_W     = 32'(DUTY_MAX);

    logic [31:0] tick_cnt;
    logic        tick;
    logic        ready_q;
    logic        accept;
    logic [31:0] tgt_mag_left, tgt_mag_right;
    logic        tgt_neg_left, tgt_neg_right;
    logic        idle_left, idle_right;

    function automatic logic [31:0] clamp_mag(input logic signed [10:0] v);
        logic [31:0] wide;
        logic [31:0] mag;
        wide = {{21{v[10]}}, v};
        mag  = v[10] ? (32'd0 - wide) : wide;
        return (mag > MAX_W) ? MAX_W : mag;
    endfunction

    assign tick   = (tick_cnt == TICK_LAST);
    assign accept = bus.cmd_valid & ready_q & ~estop;
    assign bus.cmd_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            tgt_mag_left  <= 32'd0;
            tgt_mag_right <= 32'd0;
            tgt_neg_left  <= 1'b0;
            tgt_neg_right <= 1'b0;
            settled       <= 1'b1;
        end else begin
            ready_q <= ~estop;
            settled <= idle_left & idle_right & ~estop;
            if (estop) begin
                tgt_mag_left  <= 32'd0;
                tgt_mag_right <= 32'd0;
                tgt_neg_left  <= 1'b0;
                tgt_neg_right <= 1'b0;
            end else if (accept) begin
                tgt_mag_left  <= clamp_mag(bus.cmd_left);
                tgt_mag_right <= clamp_mag(bus.cmd_right);
                tgt_neg_left  <= bus.cmd_left[10];
                tgt_neg_right <= bus.cmd_right[10];
            end
        end
    end

    motor_ramp_chan #(.STEP(STEP), .DWELL_TICKS(DWELL_TICKS)) u_left (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .estop     (estop),
        .tgt_mag   (tgt_mag_left),
        .tgt_neg   (tgt_neg_left),
        .duty      (duty_left),
        .dir       (dir_left),
        .idle_next (idle_left)
    );

    motor_ramp_chan #(.STEP(STEP), .DWELL_TICKS(DWELL_TICKS)) u_right (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .estop     (estop),
        .tgt_mag   (tgt_mag_right),
        .tgt_neg   (tgt_neg_right),
        .duty      (duty_right),
        .dir       (dir_right),
        .idle_next (idle_right)
    );
endmodule

// File: tb/tb_motor_ramp.sv
// Scoreboard bench for motor_ramp: a tick-level reference model predicts every output change.
module tb_motor_ramp;
    localparam int TICK_DIV    = 4;
    localparam int STEP        = 10;
    localparam int DUTY_MAX    = 1000;
    localparam int DWELL_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        estop;
    logic [31:0] duty_left, duty_right;
    logic        dir_left, dir_right, settled;

    motor_ramp_if bus();

    motor_ramp #(
        .TICK_DIV(TICK_DIV), .STEP(STEP), .DUTY_MAX(DUTY_MAX), .DWELL_TICKS(DWELL_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .estop      (estop),
        .duty_left  (duty_left),
        .duty_right (duty_right),
        .dir_left   (dir_left),
        .dir_right  (dir_right),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dl;
        logic        fl;
        logic [31:0] dr;
        logic        fr;
        logic        st;
        logic        rdy;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   drv_edge = 0;
    int   mon_edge = 0;
    bit   mon_en = 1'b0;

    // Reference model: plain integers per channel, dwell as a countdown of remaining ticks.
    int   m_duty[2];
    int   m_tmag[2];
    int   m_dwell[2];
    bit   m_dir[2];
    bit   m_tneg[2];
    int   ph;
    bit   m_ready, m_settled, m_acc;
    obs_t m_last;

    localparam obs_t RESET_OBS = '{dl: 32'd0, fl: 1'b1, dr: 32'd0, fr: 1'b1, st: 1'b1, rdy: 1'b0};

    function automatic bit opposing(int c);
        return (m_tmag[c] != 0) && ((!m_tneg[c]) != m_dir[c]);
    endfunction

    function automatic bit at_rest(int c);
        return (m_dwell[c] == 0) && !opposing(c) && (m_duty[c] == m_tmag[c]);
    endfunction

    function automatic void chan_edge(int c, bit tk);
        if (m_dwell[c] > 0) begin
            if (tk) begin
                m_dwell[c]--;
                if (m_dwell[c] == 0 && m_tmag[c] != 0) m_dir[c] = !m_tneg[c];
            end
        end else if (opposing(c)) begin
            if (tk) m_duty[c] = (m_duty[c] > STEP) ? m_duty[c] - STEP : 0;
            if (m_duty[c] == 0) m_dwell[c] = DWELL_TICKS;
        end else if (tk) begin
            if (m_duty[c] < m_tmag[c])
                m_duty[c] = (m_tmag[c] - m_duty[c] <= STEP) ? m_tmag[c] : m_duty[c] + STEP;
            else if (m_duty[c] > m_tmag[c])
                m_duty[c] = (m_duty[c] - m_tmag[c] <= STEP) ? m_tmag[c] : m_duty[c] - STEP;
        end
    endfunction

    function automatic void load_target(int c, logic [10:0] raw);
        int v;
        v = int'($signed(raw));
        if (v > DUTY_MAX) v = DUTY_MAX;
        if (v < -DUTY_MAX) v = -DUTY_MAX;
        m_tneg[c] = (v < 0);
        m_tmag[c] = (v < 0) ? -v : v;
    endfunction

    function automatic void clear_chan(int c);
        m_duty[c]  = 0;
        m_dwell[c] = 0;
        m_tmag[c]  = 0;
        m_tneg[c]  = 1'b0;
    endfunction

    function automatic void model_edge();
        bit   tk;
        obs_t o;
        tk    = (ph == TICK_DIV - 1);
        m_acc = 1'b0;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                clear_chan(c);
                m_dir[c] = 1'b1;
            end
            ph        = 0;
            m_ready   = 1'b0;
            m_settled = 1'b1;
        end else begin
            ph = (ph + 1) % TICK_DIV;
            if (estop) begin
                clear_chan(0);
                clear_chan(1);
                m_settled = 1'b0;
                m_ready   = 1'b0;
            end else begin
                m_acc = bus.cmd_valid && m_ready;
                chan_edge(0, tk);
                chan_edge(1, tk);
                // FSM state after an edge still reflects the targets held before it
                m_settled = at_rest(0) && at_rest(1);
                m_ready   = 1'b1;
                if (m_acc) begin
                    load_target(0, bus.cmd_left);
                    load_target(1, bus.cmd_right);
                end
            end
        end
        o = '{dl: 32'(m_duty[0]), fl: m_dir[0], dr: 32'(m_duty[1]), fr: m_dir[1],
              st: m_settled, rdy: m_ready};
        if (o != m_last) begin
            sb.push_back('{o: o, cyc: drv_edge});
            m_last = o;
        end
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, mon_edge);
        end
    endtask

    task automatic timeout(string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at edge %0d", name, drv_edge);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        drv_edge++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(int l, int r);
        bus.cmd_valid = 1'b1;
        bus.cmd_left  = l[10:0];
        bus.cmd_right = r[10:0];
        for (int i = 0; i < 20; i++) begin
            clk_edge();
            if (m_acc) break;
        end
        if (!m_acc) timeout("cmd_handshake");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rest(int budget);
        int n;
        n = 0;
        while (!(m_settled && at_rest(0) && at_rest(1)) && n < budget) begin
            clk_edge();
            n++;
        end
        if (n >= budget) timeout("wait_settle");
        repeat (2) clk_edge();
    endtask

    function automatic int rnd_cmd();
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 2047)) - 1024;
        return int'($urandom_range(0, 120)) - 60;
    endfunction

    task automatic random_phase(int iters);
        int r, n;
        for (int it = 0; it < iters; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                bus.cmd_valid = 1'b1;
                n = rnd_cmd();
                bus.cmd_left = n[10:0];
                n = rnd_cmd();
                bus.cmd_right = n[10:0];
                clk_edge();
                bus.cmd_valid = 1'b0;
            end else if (r < 65) begin
                estop = 1'b1;
                repeat ($urandom_range(1, 6)) clk_edge();
                estop = 1'b0;
            end else if (r < 68) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) clk_edge();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 30)) clk_edge();
        end
    endtask

    // Monitor: every change on the DUT outputs must match the next predicted change, on the same edge.
    initial begin
        obs_t last, cur;
        exp_t e;
        last = RESET_OBS;
        forever begin
            @(posedge clk);
            #1;
            mon_edge++;
            if (mon_en) begin
                cur = '{dl: duty_left, fl: dir_left, dr: duty_right, fr: dir_right,
                        st: settled, rdy: bus.cmd_ready};
                if (cur !== last) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unpredicted_change: outputs changed at edge %0d with no expected change", mon_edge);
                    end else begin
                        e = sb.pop_front();
                        check("change_edge", 32'(mon_edge), 32'(e.cyc));
                        check("duty_left", cur.dl, e.o.dl);
                        check("dir_left", 32'(cur.fl), 32'(e.o.fl));
                        check("duty_right", cur.dr, e.o.dr);
                        check("dir_right", 32'(cur.fr), 32'(e.o.fr));
                        check("settled", 32'(cur.st), 32'(e.o.st));
                        check("cmd_ready", 32'(cur.rdy), 32'(e.o.rdy));
                    end
                    last = cur;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        estop = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_left = '0;
        bus.cmd_right = '0;
        m_last = RESET_OBS;
        ph = 0;
        clk_edge();
        clk_edge();
        rst = 1'b0;
        sb.delete();
        mon_en = 1'b1;

        check("rst_duty_left", duty_left, 32'd0);
        check("rst_duty_right", duty_right, 32'd0);
        check("rst_dir_left", 32'(dir_left), 32'd1);
        check("rst_dir_right", 32'(dir_right), 32'd1);
        check("rst_settled", 32'(settled), 32'd1);
        check("rst_ready_low", 32'(bus.cmd_ready), 32'd0);
        clk_edge();
        check("rst_ready_high", 32'(bus.cmd_ready), 32'd1);

        send(25, 0);
        wait_rest(200);
        check("ramp_duty_left", duty_left, 32'd25);
        check("ramp_duty_right", duty_right, 32'd0);
        check("ramp_settled", 32'(settled), 32'd1);

        send(25, -1024);
        wait_rest(2000);
        check("clamp_duty_right", duty_right, 32'd1000);
        check("clamp_dir_right", 32'(dir_right), 32'd0);

        send(30, -1024);
        wait_rest(200);
        send(-20, -1024);
        wait_rest(400);
        check("rev_dir_left", 32'(dir_left), 32'd0);
        check("rev_duty_left", duty_left, 32'd20);

        send(100, -1024);
        for (int i = 0; i < 400 && !(m_duty[0] == 40 && m_dir[0]); i++) clk_edge();
        if (!(m_duty[0] == 40 && m_dir[0])) timeout("reach_duty_40");
        estop = 1'b1;
        clk_edge();
        check("estop_duty_left", duty_left, 32'd0);
        check("estop_duty_right", duty_right, 32'd0);
        check("estop_ready", 32'(bus.cmd_ready), 32'd0);
        check("estop_dir_left", 32'(dir_left), 32'd1);
        check("estop_dir_right", 32'(dir_right), 32'd0);
        repeat (4) clk_edge();
        estop = 1'b0;
        repeat (12) clk_edge();
        check("post_estop_duty_left", duty_left, 32'd0);
        check("post_estop_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_estop_settled", 32'(settled), 32'd1);

        send(30, 0);
        wait_rest(400);
        send(-30, 0);
        for (int i = 0; i < 200 && m_dwell[0] == 0; i++) clk_edge();
        if (m_dwell[0] == 0) timeout("reach_dwell");
        send(30, 0);
        wait_rest(400);
        check("dwell_cmd_dir_left", 32'(dir_left), 32'd1);
        check("dwell_cmd_duty_left", duty_left, 32'd30);

        random_phase(250);
        repeat (3) clk_edge();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
